// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine.
// Contents:
//   op_e      - operation encodings as presented on op_i
//   state_e   - engine FSM states
//   ITER      - number of iterations for a 32-bit operation
//   op_is_div / op_is_signed - operation class decode helpers
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_SIGN = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int ITER = 32;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide core (purely combinational).
// Ports:
//   div_i  - 1: restoring-divide step, 0: shift-add multiply step
//   acc_i  - current accumulator {upper half, lower half}
//   opb_i  - multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_o  - accumulator after this iteration
// Multiply: upper half is the partial product, lower half holds the
// not-yet-consumed multiplier bits. Divide: upper half is the partial
// remainder, lower half shifts dividend bits out and quotient bits in.
// The carry/borrow bit that makes the working width 2*size+1 lives only in
// the intermediate sum and remainder candidate; it is never needed between
// iterations because the stored remainder is always below the divisor and
// the shifted partial product always fits.
module muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int size = 32
) (
    input  logic                div_i,
    input  logic [2*size-1:0]   acc_i,
    input  logic [size-1:0]     opb_i,
    output logic [2*size-1:0]   acc_o
);

    logic [size:0]   sum;
    logic [size:0]   rem_sh;
    logic [size-1:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*size-1:size]} + {1'b0, opb_i};
        // Partial remainder shifted left with the next dividend bit appended.
        rem_sh = acc_i[2*size-1:size-1];
        // The true difference is below the divisor whenever it is kept, so
        // modulo-2^size subtraction yields the exact new remainder.
        diff   = rem_sh[size-1:0] - opb_i;
        acc_o  = acc_i;
        if (div_i) begin
            if (rem_sh >= {1'b0, opb_i}) begin
                acc_o = {diff, acc_i[size-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*size-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[size-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*size-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MULT/MULTU/DIV/DIVU engine with the architectural HI/LO register pair.
// Operands are reduced to magnitudes at launch, iterated unsigned for `iter`
// cycles, then sign-corrected in a single SIGN cycle before HI/LO update.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   start_i, op_i         - launch request and operation (accepted in IDLE/DONE)
//   rs_data_i, rt_data_i  - multiplicand/dividend, multiplier/divisor
//   abort_i               - kill the in-flight operation (CALC/SIGN only)
//   hi_we_i, lo_we_i, wdata_i - MTHI/MTLO writes, honoured while not busy
//   busy_o                - operation in progress (CALC, SIGN)
//   done_o                - one-cycle pulse after HI/LO take a result
//   hi_o, lo_o            - HI and LO registers
module mul_div_unit
    import mips_muldiv_pkg::*;
#(
    parameter int size = 32,
    parameter int iter = ITER
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] rs_data_i,
    input  logic [size-1:0] rt_data_i,
    input  logic            abort_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [size-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [size-1:0] hi_o,
    output logic [size-1:0] lo_o
);

    localparam int CNT_W = $clog2(iter);

    function automatic logic [size-1:0] abs_val(input logic [size-1:0] v, input logic sgn);
        logic signed [size-1:0] sv;
        sv = v;
        if (sgn && (sv < 0)) begin
            return -sv;
        end
        return v;
    endfunction

    function automatic logic [size-1:0] cond_neg(input logic [size-1:0] v, input logic n);
        logic signed [size-1:0] sv;
        sv = v;
        return n ? -sv : sv;
    endfunction

    function automatic logic [2*size-1:0] cond_neg_wide(input logic [2*size-1:0] v, input logic n);
        logic signed [2*size-1:0] sv;
        sv = v;
        return n ? -sv : sv;
    endfunction

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [size-1:0]   hi_q;
    logic [size-1:0]   lo_q;

    logic [2*size-1:0] acc_q;
    logic [2*size-1:0] acc_d;
    logic [size-1:0]   opb_q;
    logic              div_q;
    logic              neg_lo_q;   // product sign (multiply) or quotient sign
    logic              neg_hi_q;   // remainder sign (divide only)

    logic [size-1:0]   hi_res_d;
    logic [size-1:0]   lo_res_d;

    op_e               op_in;
    logic              in_div;
    logic              in_sgn;
    logic              div_zero;
    logic              accept;

    assign op_in    = op_e'(op_i);
    assign in_div   = op_is_div(op_in);
    assign in_sgn   = op_is_signed(op_in);
    assign div_zero = in_div && (rt_data_i == '0);
    assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

    muldiv_step #(.size(size)) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .opb_i (opb_q),
        .acc_o (acc_d)
    );

    // Final sign correction applied in the SIGN cycle.
    always_comb begin
        hi_res_d = '0;
        lo_res_d = '0;
        if (div_q) begin
            hi_res_d = cond_neg(acc_q[2*size-1:size], neg_hi_q);
            lo_res_d = cond_neg(acc_q[size-1:0], neg_lo_q);
        end else begin
            {hi_res_d, lo_res_d} = cond_neg_wide(acc_q, neg_lo_q);
        end
    end

    // Control and architectural state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (start_i) begin
                        state_q <= S_CALC;
                        cnt_q   <= CNT_W'(iter - 1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_SIGN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SIGN: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= hi_res_d;
                        lo_q    <= lo_res_d;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath: magnitudes and sign flags at launch, one step per CALC cycle.
    // Divide by zero keeps the raw dividend and suppresses sign correction so
    // the iteration naturally yields HI=rs, LO=all ones.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc_q    <= {{size{1'b0}}, div_zero ? rs_data_i : abs_val(rs_data_i, in_sgn)};
            opb_q    <= abs_val(rt_data_i, in_sgn);
            div_q    <= in_div;
            neg_lo_q <= in_sgn && !div_zero && (rs_data_i[size-1] ^ rt_data_i[size-1]);
            neg_hi_q <= in_sgn && !div_zero && rs_data_i[size-1];
        end else if (state_q == S_CALC) begin
            acc_q <= acc_d;
        end
    end

    assign busy_o = (state_q == S_CALC) || (state_q == S_SIGN);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU engine for the MIPS core.
- Owns the HI/LO register pair.
- hi_o and lo_o feed the write-back 4-to-1 select mux directly as its data2/data3 inputs, for MFHI/MFLO.
- Hazard logic stalls the pipeline while busy_o is high.

Parameters:
- size, 32, operand and HI/LO width. Only 32 is required to be verified.
- iter, 32, iteration count. Must equal size.

Ports:
- clk_i  input  1  core clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  launch the operation in op_i. Sampled only in IDLE/DONE.
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data_i  input  size  multiplicand / dividend.
- rt_data_i  input  size  multiplier / divisor.
- abort_i  input  1  pipeline flush. Kills the in-flight operation.
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  size  MTHI/MTLO data.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse: HI/LO just updated by an operation.
- hi_o  output  size  HI register.
- lo_o  output  size  LO register.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, HI=0, LO=0, busy_o=0, done_o=0, counter=0. Reset has priority over all other inputs and applies mid-operation.
- States: IDLE, CALC, SIGN, DONE. busy_o=1 in CALC and SIGN only; done_o=1 in DONE only. All outputs are registered or pure state decode.
- IDLE/DONE with start_i=1 at edge T0:
  - Latch op.
  - Latch |rs| and |rt| (absolute values for signed ops, raw values for unsigned ops).
  - Latch the result sign flags: product sign = rs xor rt; quotient sign = rs xor rt; remainder sign = rs.
  - Set counter=iter-1. Go to CALC.
- DONE with start_i=0: go to IDLE.
- CALC: one iteration per edge, T1..T32.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
  - Counter decrements each edge. At the edge where counter==0, go to SIGN.
- SIGN, edge T33:
  - Apply two's-complement negation per the sign flags.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
  - Go to DONE.
- Timing: start sampled at T0 → busy_o high T0+..T33 → done_o high for the cycle after T33. HI/LO new values are visible when done_o=1.
- Divide by zero (rt=0, DIV or DIVU): HI=rs_data_i, LO=32'hFFFFFFFF. No sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- start_i while busy_o=1: ignored. No queueing.
- abort_i=1 in CALC or SIGN: go to IDLE at that edge. HI/LO unchanged; no done_o.
- abort_i in IDLE/DONE: no effect on start.
- abort_i has priority over start_i in the same cycle.
- MTHI/MTLO:
  - hi_we_i / lo_we_i honoured only when busy_o=0. HI/LO update at that edge; done_o is not pulsed.
  - Ignored while busy_o=1.
  - Write in the same cycle as start_i: the write lands at T0; the operation result overwrites at T33.
- Arithmetic: internal accumulator is 2*size+1 bits. Negation is modulo 2^size (2^2size for the product).

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State encoding S_IDLE/S_CALC/S_SIGN/S_DONE.
  - Constant ITER=32.
- One natural sub-module: muldiv_step, combinational. Given op class, accumulator and operand, it returns the next accumulator for one shift-add or restoring-divide iteration.
- The top level holds the FSM, counter, sign logic and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done_o exactly in the cycle following edge T33; busy_o high 33 cycles.
- MULT rs=0xFFFFFFFD (−3), rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → HI=7, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- start DIVU 100/7, then start_i=1 with different operands at T5 → ignored; result HI=2, LO=14; hi_we_i at T10 ignored.
- abort_i at T12 of a MULT → IDLE next cycle, no done_o, HI/LO keep the prior values; rst_i at T20 of a DIV → HI=LO=0, busy_o=0.
- MTLO 0x12345678 while idle → lo_o=0x12345678 next cycle, done_o stays 0; back-to-back start in the DONE cycle accepted, second result correct.
